// File: rtl/ccg_bist_pkg.sv
// ccg_bist_pkg: shared FSM type, mode encodings, default MISR polynomial and LFSR tap table
package ccg_bist_pkg;
  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;
  localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C1_1DB7;
  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_LFSR = 1'b1;
  function automatic logic [31:0] tap(input int n);
    return 32'd1 << (n - 1);
  endfunction
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      3: return tap(3) | tap(2);
      4: return tap(4) | tap(3);
      5: return tap(5) | tap(3);
      6: return tap(6) | tap(5);
      7: return tap(7) | tap(6);
      8: return tap(8) | tap(6) | tap(5) | tap(4);
      9: return tap(9) | tap(5);
      10: return tap(10) | tap(7);
      11: return tap(11) | tap(9);
      12: return tap(12) | tap(6) | tap(4) | tap(1);
      13: return tap(13) | tap(4) | tap(3) | tap(1);
      14: return tap(14) | tap(5) | tap(3) | tap(1);
      15: return tap(15) | tap(14);
      16: return tap(16) | tap(15) | tap(13) | tap(4);
      17: return tap(17) | tap(14);
      18: return tap(18) | tap(11);
      19: return tap(19) | tap(6) | tap(2) | tap(1);
      20: return tap(20) | tap(17);
      21: return tap(21) | tap(19);
      22: return tap(22) | tap(21);
      23: return tap(23) | tap(18);
      24: return tap(24) | tap(23) | tap(22) | tap(17);
      25: return tap(25) | tap(22);
      26: return tap(26) | tap(6) | tap(2) | tap(1);
      27: return tap(27) | tap(5) | tap(2) | tap(1);
      28: return tap(28) | tap(25);
      29: return tap(29) | tap(27);
      30: return tap(30) | tap(6) | tap(4) | tap(1);
      31: return tap(31) | tap(28);
      32: return tap(32) | tap(22) | tap(2) | tap(1);
      default: return tap(w) | tap(w - 1);
    endcase
  endfunction
endpackage

// File: rtl/ccg_bist_sequencer_misr.sv
// ccg_misr: Galois MISR with synchronous clear and capture enable
module ccg_misr
  import ccg_bist_pkg::*;
#(
  parameter int W = 32,
  parameter int D_W = 26,
  parameter logic [W-1:0] POLY = W'(MISR_POLY_DEFAULT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [D_W-1:0] d,
  output logic [W-1:0]   sig
);
  always_ff @(posedge clk)
    sig <= rst || clr ? '0 : en ? {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ W'(d) : sig;
endmodule

// File: rtl/ccg_bist_sequencer.sv
// ccg_bist_sequencer: drives counter/LFSR vectors into a combinational CUT and compacts responses into a MISR
module ccg_bist_sequencer
  import ccg_bist_pkg::*;
#(
  parameter int IN_W = 21,
  parameter int OUT_W = 26,
  parameter int MISR_W = 32,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEFAULT),
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [IN_W-1:0]   seed,
  input  logic [31:0]       num_vectors,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic [31:0]       vec_idx
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [IN_W-1:0] TAPS = IN_W'(lfsr_taps(IN_W));
  state_t state, state_n;
  logic mode_r, start_ok, capture, last;
  logic [31:0] nvec;
  logic [SW-1:0] settle;
  logic [IN_W-1:0] first_vec, next_vec;
  assign start_ok = state == S_IDLE && start;
  assign last = vec_idx == nvec - 32'd1;
  assign capture = state == S_APPLY && !abort && settle == SW'(SETTLE - 1);
  assign first_vec = mode == MODE_LFSR ? (seed == '0 ? IN_W'(1) : seed) : '0;
  assign next_vec = mode_r == MODE_LFSR ? {dut_in[IN_W-2:0], ^(dut_in & TAPS)} : dut_in + IN_W'(1);
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_DONE;
    state_n = state == S_IDLE ? (start ? (num_vectors == '0 ? S_DONE : S_APPLY) : S_IDLE)
            : state == S_APPLY ? (abort ? S_IDLE : capture && last ? S_DONE : S_APPLY)
            : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in <= '0;
      vec_idx <= '0;
      nvec <= '0;
      mode_r <= MODE_COUNT;
      settle <= '0;
    end else if (start_ok) begin
      mode_r <= mode;
      nvec <= num_vectors;
      vec_idx <= '0;
      settle <= '0;
      if (num_vectors != '0) dut_in <= first_vec;
    end else if (state == S_APPLY && !abort) begin
      settle <= capture ? '0 : settle + SW'(1);
      if (capture && !last) begin
        dut_in <= next_vec;
        vec_idx <= vec_idx + 32'd1;
      end
    end
  end
  ccg_misr #(.W(MISR_W), .D_W(OUT_W), .POLY(MISR_POLY)) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(start_ok),
    .en(capture),
    .d(dut_out),
    .sig(signature)
  );
endmodule

// File: tb/tb_ccg_bist_sequencer.sv
// tb_ccg_bist_sequencer: directed and randomized runs of two sequencers (SETTLE 1 and 3) against a run-level model
module tb_ccg_bist_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0, mode = 0, ab_en = 0;
  logic [20:0] seed = '0;
  logic [31:0] num_vectors = '0;
  logic [1:0] rsel = '0;
  logic [20:0] o_in [2];
  logic [25:0] o_out [2];
  logic [1:0] o_busy, o_done;
  logic [31:0] o_sig [2], o_idx [2];
  int n_vec = 0, n_mis = 0, cur = 0;
  bit checking = 0;
  int m_act [2], m_t [2], m_n [2];
  logic [20:0] m_vecs [2][64];
  logic e_busy [2], e_done [2];
  logic [20:0] e_in [2];
  logic [31:0] e_idx [2], e_sig [2];
  always #5 clk = ~clk;
  function automatic logic [25:0] resp(input logic [1:0] sel, input logic [20:0] v);
    return sel == 2'd0 ? 26'(v) : sel == 2'd1 ? 26'd1 : {v[4:0] ^ 5'h15, v ^ 21'h1ABCDE};
  endfunction
  function automatic logic [20:0] lfsr21(input logic [20:0] v);
    return {v[19:0], v[20] ^ v[18]};
  endfunction
  function automatic logic [31:0] misr(input logic [31:0] s, input logic [25:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ 32'(d);
  endfunction
  function automatic logic [31:0] sig_of(input int i, input int cap);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < cap; j++) s = misr(s, resp(rsel, m_vecs[i][j]));
    return s;
  endfunction
  assign o_out[0] = resp(rsel, o_in[0]);
  assign o_out[1] = resp(rsel, o_in[1]);
  ccg_bist_sequencer #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .num_vectors(num_vectors), .dut_in(o_in[0]), .dut_out(o_out[0]), .busy(o_busy[0]),
    .done(o_done[0]), .signature(o_sig[0]), .vec_idx(o_idx[0])
  );
  ccg_bist_sequencer #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .num_vectors(num_vectors), .dut_in(o_in[1]), .dut_out(o_out[1]), .busy(o_busy[1]),
    .done(o_done[1]), .signature(o_sig[1]), .vec_idx(o_idx[1])
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, cap;
      s = i == 0 ? 1 : 3;
      if (rst) begin
        m_act[i] = 0;
        e_busy[i] = 0;
        e_done[i] = 0;
        e_in[i] = '0;
        e_idx[i] = '0;
        e_sig[i] = '0;
      end else begin
        if (m_act[i] != 0) begin
          if (abort || m_t[i] == m_n[i] * s + 1) m_act[i] = 0;
          else m_t[i]++;
        end else if (start) begin
          logic [20:0] v;
          m_act[i] = 1;
          m_t[i] = 1;
          m_n[i] = int'(num_vectors);
          v = mode ? (seed == '0 ? 21'd1 : seed) : 21'd0;
          for (int k = 0; k < 64; k++) begin
            m_vecs[i][k] = v;
            v = mode ? lfsr21(v) : v + 21'd1;
          end
        end
        if (m_act[i] != 0) begin
          cap = (m_t[i] - 1) / s;
          e_busy[i] = 1;
          e_done[i] = m_t[i] == m_n[i] * s + 1;
          e_sig[i] = sig_of(i, cap);
          e_idx[i] = m_n[i] == 0 ? 32'd0 : 32'(cap < m_n[i] ? cap : m_n[i] - 1);
          if (m_n[i] != 0) e_in[i] = m_vecs[i][e_idx[i]];
        end else begin
          e_busy[i] = 0;
          e_done[i] = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(e_busy[i]));
        chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(e_done[i]));
        chk($sformatf("dut_in%0d", i), 32'(o_in[i]), 32'(e_in[i]));
        chk($sformatf("vec_idx%0d", i), o_idx[i], e_idx[i]);
        chk($sformatf("signature%0d", i), o_sig[i], e_sig[i]);
      end
    end
  end
  task automatic start_run(input logic m, input logic [20:0] s, input logic [31:0] n);
    mode = m;
    seed = s;
    num_vectors = n;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    cur = 1;
  endtask
  task automatic at(input int c);
    repeat (c - cur) @(posedge clk);
    cur = c;
    @(negedge clk);
  endtask
  task automatic wait_idle;
    int b;
    b = 0;
    while (o_busy != 2'b00 && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (o_busy != 2'b00) begin
      n_vec++;
      n_mis++;
      $display("FAIL idle_timeout: busy=%b, want 00", o_busy);
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checking = 1;
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_dut_in", 32'(o_in[0]), 32'd0);
    chk("rst_sig", o_sig[0], 32'd0);
    chk("rst_idx", o_idx[0], 32'd0);
    rsel = 2'd0;
    start_run(1'b0, 21'd0, 32'd4);
    at(1); chk("ex_v0", 32'(o_in[0]), 32'd0);
    at(2); chk("ex_v1", 32'(o_in[0]), 32'd1);
    at(3); chk("ex_v2", 32'(o_in[0]), 32'd2);
    at(4); chk("ex_v3", 32'(o_in[0]), 32'd3);
    at(5);
    chk("ex_done", 32'(o_done[0]), 32'd1);
    chk("ex_sig", o_sig[0], 32'h0000_0003);
    chk("model_ex_sig", e_sig[0], 32'h0000_0003);
    at(6); chk("ex_busy_low", 32'(o_busy[0]), 32'd0);
    wait_idle;
    start_run(1'b1, 21'd1, 32'd25);
    at(1); chk("lfsr_v0", 32'(o_in[0]), 32'h000001);
    at(2); chk("lfsr_v1", 32'(o_in[0]), 32'h000002);
    at(3); chk("lfsr_v2", 32'(o_in[0]), 32'h000004);
    at(20);
    chk("lfsr_v19", 32'(o_in[0]), 32'h080001);
    chk("model_lfsr_v19", 32'(e_in[0]), 32'h080001);
    wait_idle;
    start_run(1'b1, 21'd0, 32'd25);
    at(1); chk("seed0_v0", 32'(o_in[0]), 32'h000001);
    at(20); chk("seed0_v19", 32'(o_in[0]), 32'h080001);
    wait_idle;
    rsel = 2'd1;
    start_run(1'b0, 21'd0, 32'd2);
    at(3); chk("s3_hold_v0", 32'(o_in[1]), 32'd0);
    at(4); chk("s3_v1", 32'(o_in[1]), 32'd1);
    at(6); chk("s3_not_done", 32'(o_done[1]), 32'd0);
    at(7);
    chk("s3_done", 32'(o_done[1]), 32'd1);
    chk("s3_sig", o_sig[1], 32'h0000_0003);
    at(8); chk("s3_busy_low", 32'(o_busy[1]), 32'd0);
    wait_idle;
    start_run(1'b0, 21'd0, 32'd0);
    at(1);
    chk("n0_done", 32'(o_done), 32'd3);
    chk("n0_busy", 32'(o_busy), 32'd3);
    chk("n0_sig", o_sig[0], 32'd0);
    at(2); chk("n0_busy_low", 32'(o_busy), 32'd0);
    wait_idle;
    rsel = 2'd0;
    start_run(1'b0, 21'd0, 32'd8);
    at(3);
    abort = 1;
    at(4);
    abort = 0;
    chk("ab_busy", 32'(o_busy), 32'd0);
    chk("ab_idx", o_idx[0], 32'd2);
    chk("ab_sig", o_sig[0], 32'd1);
    wait_idle;
    start_run(1'b1, 21'h12345, 32'd8);
    at(3);
    rst = 1;
    at(4);
    rst = 0;
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_dut_in", 32'(o_in[0]), 32'd0);
    chk("mrst_idx", o_idx[0], 32'd0);
    chk("mrst_sig", o_sig[0], 32'd0);
    wait_idle;
    mode = 0;
    num_vectors = 32'd4;
    start = 1;
    @(posedge clk);
    #1 cur = 1;
    at(5); chk("hold_done", 32'(o_done[0]), 32'd1);
    at(6);
    chk("hold_idle", 32'(o_busy[0]), 32'd0);
    chk("hold_sig", o_sig[0], 32'd3);
    at(7);
    chk("restart_busy", 32'(o_busy[0]), 32'd1);
    chk("restart_sig", o_sig[0], 32'd0);
    chk("restart_idx", o_idx[0], 32'd0);
    start = 0;
    wait_idle;
    for (int r = 0; r < 40; r++) begin
      rsel = 2'($urandom_range(0, 2));
      ab_en = $urandom_range(0, 2) == 0;
      start_run(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? 21'd0 : 21'($urandom),
                32'($urandom_range(0, 12)));
      for (int c = 0; c < 120 && o_busy != 2'b00; c++) begin
        @(negedge clk);
        abort = ab_en && $urandom_range(0, 15) == 0;
        start = $urandom_range(0, 11) == 0;
      end
      abort = 0;
      start = 0;
      wait_idle;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
